// File: rtl/aes_pkg.sv
// Shared AES sizing constants, key-size encoding, word/round-key types
// and the GF(2^8) doubling helper used by the key-expansion engine.
package aes_pkg;

  typedef enum logic [1:0] {
    KEY_128 = 2'b00,
    KEY_192 = 2'b01,
    KEY_256 = 2'b10,
    KEY_BAD = 2'b11
  } key_size_e;

  typedef enum logic {
    ST_IDLE,
    ST_EXPAND
  } state_e;

  typedef logic [31:0]  word_t;
  typedef logic [127:0] round_key_t;
  typedef logic [255:0] cipher_key_t;

  localparam int unsigned WINDOW = 8;

  localparam logic [7:0] RCON_INIT = 8'h01;

  localparam logic [3:0] NK_128 = 4'd4;
  localparam logic [3:0] NK_192 = 4'd6;
  localparam logic [3:0] NK_256 = 4'd8;

  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_192 = 4'd12;
  localparam logic [3:0] NR_256 = 4'd14;

  // Number of 32-bit words in the cipher key.
  function automatic logic [3:0] nk_of(input key_size_e ks);
    case (ks)
      KEY_128: return NK_128;
      KEY_192: return NK_192;
      KEY_256: return NK_256;
      default: return 4'd0;
    endcase
  endfunction

  // Number of cipher rounds; the key schedule produces Nr+1 round keys.
  function automatic logic [3:0] nr_of(input key_size_e ks);
    case (ks)
      KEY_128: return NR_128;
      KEY_192: return NR_192;
      KEY_256: return NR_256;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic key_size_legal(input key_size_e ks);
    return ks != KEY_BAD;
  endfunction

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1 (0x80 -> 0x1b).
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_round_key_gen_if.sv
// Request/response bundle between a key-expansion client and the
// round-key generator. The client (master) launches expansions; the
// generator (slave) streams round keys back.
interface aes_round_key_gen_if;
  import aes_pkg::*;

  logic        start;
  logic        abort;
  logic [1:0]  key_size;
  cipher_key_t key_in;

  round_key_t  round_key;
  logic [3:0]  round_idx;
  logic        key_valid;
  logic [3:0]  round_amount;
  logic        busy;
  logic        done;

  modport master (
    output start, abort, key_size, key_in,
    input  round_key, round_idx, key_valid, round_amount, busy, done
  );

  modport slave (
    input  start, abort, key_size, key_in,
    output round_key, round_idx, key_valid, round_amount, busy, done
  );

endinterface

// File: rtl/aes_sub_word.sv
// SubWord: applies the AES S-box to each byte of a 32-bit word.
// Purely combinational; four parallel table lookups.
module aes_sub_word
  import aes_pkg::*;
(
  input  word_t din,
  output word_t dout
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Substitute every byte of the input word through the S-box.
  always_comb begin
    dout = {SBOX[din[31:24]], SBOX[din[23:16]], SBOX[din[15:8]], SBOX[din[7:0]]};
  end

endmodule

// File: rtl/aes_round_key_gen.sv
// Iterative AES-128/192/256 key expansion. Produces one schedule word
// per cycle from an 8-word history window and emits each completed
// 128-bit round key together with its round index.
module aes_round_key_gen
  import aes_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  aes_round_key_gen_if.slave   bus
);

  state_e      state_q, state_d;

  cipher_key_t key_q;
  logic [3:0]  nk_q;
  logic [5:0]  last_word_q;
  logic [5:0]  word_cnt_q;
  logic [2:0]  mod_cnt_q;
  logic [7:0]  rcon_q;
  word_t       window_q [WINDOW];

  round_key_t  round_key_q;
  logic [3:0]  round_idx_q;
  logic        key_valid_q;
  logic [3:0]  round_amount_q;
  logic        busy_q;
  logic        done_q;

  key_size_e   req_size;
  logic        accept;
  logic        expanding;
  logic        aborting;
  logic        last_word;
  logic        is_key_word;
  word_t       tap_nk;
  word_t       sub_in;
  word_t       sub_out;
  word_t       new_word;

  assign req_size    = key_size_e'(bus.key_size);
  // busy_q is still high in the done cycle, which keeps a start on the
  // edge where busy falls from relaunching the engine.
  assign accept      = (state_q == ST_IDLE) && !busy_q && bus.start && key_size_legal(req_size);
  assign aborting    = (state_q == ST_EXPAND) && bus.abort;
  assign expanding   = (state_q == ST_EXPAND) && !bus.abort;
  assign last_word   = (word_cnt_q == last_word_q);
  assign is_key_word = (word_cnt_q < {2'b00, nk_q});

  aes_sub_word u_sub_word (
    .din  (sub_in),
    .dout (sub_out)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: launch on a legal start, return after the last word or on abort.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_EXPAND;
        end
      end
      ST_EXPAND: begin
        if (bus.abort || last_word) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Compute w[i] from the key register or from w[i-1] and the Nk-selected tap w[i-Nk].
  always_comb begin
    case (nk_q)
      NK_128:  tap_nk = window_q[3];
      NK_192:  tap_nk = window_q[5];
      default: tap_nk = window_q[7];
    endcase

    if (mod_cnt_q == 3'd0) begin
      sub_in = {window_q[0][23:0], window_q[0][31:24]};
    end else begin
      sub_in = window_q[0];
    end

    if (is_key_word) begin
      new_word = key_q[255:224];
    end else if (mod_cnt_q == 3'd0) begin
      new_word = tap_nk ^ sub_out ^ {rcon_q, 24'h000000};
    end else if ((nk_q == NK_256) && (mod_cnt_q == 3'd4)) begin
      new_word = tap_nk ^ sub_out;
    end else begin
      new_word = tap_nk ^ window_q[0];
    end
  end

  // Expansion datapath: capture on start, then advance one word per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q       <= '0;
      nk_q        <= '0;
      last_word_q <= '0;
      word_cnt_q  <= '0;
      mod_cnt_q   <= '0;
      rcon_q      <= '0;
      for (int j = 0; j < WINDOW; j++) begin
        window_q[j] <= '0;
      end
    end else if (accept) begin
      key_q       <= bus.key_in;
      nk_q        <= nk_of(req_size);
      last_word_q <= {nr_of(req_size), 2'b11};
      word_cnt_q  <= '0;
      mod_cnt_q   <= '0;
      rcon_q      <= RCON_INIT;
    end else if (expanding) begin
      key_q       <= {key_q[223:0], 32'h00000000};
      window_q[0] <= new_word;
      for (int j = 1; j < WINDOW; j++) begin
        window_q[j] <= window_q[j-1];
      end
      word_cnt_q  <= word_cnt_q + 6'd1;
      if ({1'b0, mod_cnt_q} == (nk_q - 4'd1)) begin
        mod_cnt_q <= '0;
      end else begin
        mod_cnt_q <= mod_cnt_q + 3'd1;
      end
      if ((mod_cnt_q == 3'd0) && !is_key_word) begin
        rcon_q <= xtime(rcon_q);
      end
    end
  end

  // Output registers: round-key strobe on every fourth word, busy/done bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      round_key_q    <= '0;
      round_idx_q    <= '0;
      key_valid_q    <= 1'b0;
      round_amount_q <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      done_q      <= 1'b0;
      if (accept) begin
        busy_q         <= 1'b1;
        round_amount_q <= nr_of(req_size);
      end else if (aborting) begin
        busy_q <= 1'b0;
      end else if (expanding) begin
        if (word_cnt_q[1:0] == 2'b11) begin
          round_key_q <= {window_q[2], window_q[1], window_q[0], new_word};
          round_idx_q <= word_cnt_q[5:2];
          key_valid_q <= 1'b1;
          done_q      <= last_word;
        end
      end else if (done_q) begin
        busy_q <= 1'b0;
      end
    end
  end

  assign bus.round_key    = round_key_q;
  assign bus.round_idx    = round_idx_q;
  assign bus.key_valid    = key_valid_q;
  assign bus.round_amount = round_amount_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;

endmodule

// File: tb/tb_aes_round_key_gen.sv
// Self-checking bench for aes_round_key_gen. Expected round keys come from
// a FIPS-197 style key schedule whose S-box is derived from GF(2^8)
// inversion plus the affine map, checked cycle by cycle against the DUT.
module tb_aes_round_key_gen;

  logic clk;
  logic rst_n;

  int checks;
  int errors;

  logic [7:0]   sboxModel [256];
  logic [127:0] modelRk [15];
  int           modelNr;
  logic [127:0] holdKey;
  logic [3:0]   holdIdx;

  aes_round_key_gen_if bus ();

  aes_round_key_gen dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int n = 0; n < 8; n++) begin
      if (b[n]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [31:0] subWordModel(input logic [31:0] t);
    return {sboxModel[t[31:24]], sboxModel[t[23:16]], sboxModel[t[15:8]], sboxModel[t[7:0]]};
  endfunction

  task automatic buildSbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0) begin
        for (int y = 1; y < 256; y++) begin
          if (gmul(x[7:0], y[7:0]) == 8'h01) inv = y[7:0];
        end
      end
      sboxModel[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic buildModel(input logic [1:0] ks, input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int          nk;
    nk      = 4 + 2 * int'(ks);
    modelNr = nk + 6;
    rc      = 8'h01;
    for (int i = 0; i < 4 * (modelNr + 1); i++) begin
      if (i < nk) begin
        w[i] = key[255 - 32 * i -: 32];
      end else begin
        t = w[i - 1];
        if (i % nk == 0) begin
          t  = subWordModel({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
          rc = gmul(rc, 8'h02);
        end else if (nk == 8 && i % nk == 4) begin
          t = subWordModel(t);
        end
        w[i] = w[i - nk] ^ t;
      end
    end
    for (int r = 0; r <= modelNr; r++) begin
      modelRk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    end
  endtask

  task automatic applyStimulus(input logic s, input logic a, input logic [1:0] ks, input logic [255:0] key);
    bus.start    = s;
    bus.abort    = a;
    bus.key_size = ks;
    bus.key_in   = key;
  endtask

  task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [255:0] randKey();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"}, 256'(bus.busy), 256'd0);
    checkOutput({tag, "_valid"}, 256'(bus.key_valid), 256'd0);
    checkOutput({tag, "_done"}, 256'(bus.done), 256'd0);
    checkOutput({tag, "_key"}, 256'(bus.round_key), 256'd0);
    checkOutput({tag, "_idx"}, 256'(bus.round_idx), 256'd0);
    checkOutput({tag, "_amount"}, 256'(bus.round_amount), 256'd0);
  endtask

  // Runs one expansion and checks every cycle. Entered and left at posedge+1.
  task automatic runExpansion(input string name, input logic [1:0] ks, input logic [255:0] key,
                              input int abortK, input int resetK, input int midStartK,
                              input bit haveKnown, input logic [127:0] knownLast);
    int lastK;
    int strobes;
    int idx;
    bit expValid;
    buildModel(ks, key);
    lastK   = 4 * modelNr + 4;
    strobes = 0;
    applyStimulus(1'b1, 1'b0, ks, key);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, 2'($urandom_range(0, 3)), randKey());
    checkOutput({name, "_busy_e0"}, 256'(bus.busy), 256'd1);
    checkOutput({name, "_amount_e0"}, 256'(bus.round_amount), 256'(modelNr));
    checkOutput({name, "_valid_e0"}, 256'(bus.key_valid), 256'd0);
    for (int k = 1; k <= lastK + 2; k++) begin
      bus.abort = (k == abortK);
      bus.start = (k == midStartK) || (k == lastK + 1);
      if (bus.start) begin
        bus.key_size = 2'($urandom_range(0, 2));
        bus.key_in   = randKey();
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      if (k == resetK) begin
        #2 rst_n = 1'b0;
        #1 checkAllZero({name, "_async_rst"});
        holdKey = '0;
        holdIdx = '0;
        @(posedge clk); #1;
        checkAllZero({name, "_in_rst"});
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkAllZero({name, "_after_rst"});
        return;
      end
      if (abortK > 0 && k >= abortK) begin
        checkOutput({name, "_abort_busy"}, 256'(bus.busy), 256'd0);
        checkOutput({name, "_abort_valid"}, 256'(bus.key_valid), 256'd0);
        checkOutput({name, "_abort_done"}, 256'(bus.done), 256'd0);
        checkOutput({name, "_abort_key_hold"}, 256'(bus.round_key), 256'(holdKey));
        checkOutput({name, "_abort_amount"}, 256'(bus.round_amount), 256'(modelNr));
        if (k >= abortK + 3) return;
        continue;
      end
      expValid = (k % 4 == 0) && (k <= lastK);
      checkOutput({name, "_busy"}, 256'(bus.busy), 256'(k <= lastK));
      checkOutput({name, "_valid"}, 256'(bus.key_valid), 256'(expValid));
      checkOutput({name, "_done"}, 256'(bus.done), 256'(k == lastK));
      if (expValid) begin
        idx = k / 4 - 1;
        strobes++;
        checkOutput({name, "_idx"}, 256'(bus.round_idx), 256'(idx));
        checkOutput({name, "_round_key"}, 256'(bus.round_key), 256'(modelRk[idx]));
        if (idx == 0) checkOutput({name, "_round0_is_key"}, 256'(bus.round_key), 256'(key[255:128]));
        if (haveKnown && idx == modelNr) checkOutput({name, "_fips_last"}, 256'(bus.round_key), 256'(knownLast));
        holdKey = modelRk[idx];
        holdIdx = 4'(idx);
      end else begin
        checkOutput({name, "_key_hold"}, 256'(bus.round_key), 256'(holdKey));
        checkOutput({name, "_idx_hold"}, 256'(bus.round_idx), 256'(holdIdx));
      end
    end
    checkOutput({name, "_strobe_count"}, 256'(strobes), 256'(modelNr + 1));
    checkOutput({name, "_amount_end"}, 256'(bus.round_amount), 256'(modelNr));
  endtask

  // Directed scenario sequence followed by randomized keys.
  initial begin
    logic [255:0] k128;
    logic [255:0] k192;
    logic [255:0] k256;
    checks  = 0;
    errors  = 0;
    holdKey = '0;
    holdIdx = '0;
    rst_n   = 1'b0;
    applyStimulus(1'b0, 1'b0, 2'b00, '0);
    buildSbox();
    k128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    k192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    k256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    repeat (2) @(posedge clk);
    #1 checkAllZero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] AES-128 known answer with mid-run start");
    runExpansion("a1", 2'b00, k128, 0, 0, 13, 1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    $display("[TB] AES-192 known answer");
    runExpansion("a2", 2'b01, k192, 0, 0, 21, 1'b1, 128'he98ba06f448c773c8ecc720401002202);

    $display("[TB] AES-256 known answer");
    runExpansion("a3", 2'b10, k256, 0, 0, 0, 1'b1, 128'hfe4890d1e6188d0b046df344706c631e);

    $display("[TB] abort at E20 then restart");
    runExpansion("abort", 2'b00, k128, 20, 0, 0, 1'b0, '0);
    runExpansion("restart", 2'b00, k128, 0, 0, 0, 1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    $display("[TB] illegal key size ignored");
    applyStimulus(1'b1, 1'b0, 2'b11, randKey());
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, 2'b00, '0);
    for (int c = 0; c < 6; c++) begin
      checkOutput("illegal_busy", 256'(bus.busy), 256'd0);
      checkOutput("illegal_valid", 256'(bus.key_valid), 256'd0);
      @(posedge clk); #1;
    end

    $display("[TB] randomized keys");
    for (int n = 0; n < 4; n++) begin
      runExpansion("rand", 2'($urandom_range(0, 2)), randKey(), 0, 0, int'($urandom_range(5, 40)), 1'b0, '0);
    end

    $display("[TB] async reset mid-run, then AES-256");
    runExpansion("rst", 2'($urandom_range(0, 2)), randKey(), 0, 30, 0, 1'b0, '0);
    runExpansion("post_rst", 2'b10, randKey(), 0, 0, 0, 1'b0, '0);
    runExpansion("post_rst_fips", 2'b10, k256, 0, 0, 0, 1'b1, 128'hfe4890d1e6188d0b046df344706c631e);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
